// File: rtl/forward_table_server_pkg.sv
// Shared defaults and FSM encoding for the flow-table responder.
// The parity build is selected with the FWD_TABLE_PARITY_EN macro in the top module.
package forward_table_server_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 9;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/forward_table_server_table_ram_dp.sv
// Inferred dual-port table RAM with registered reads.
// Port A is a lookup read port; port B is a read-first read/write port.
module table_ram_dp #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 9
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic [DATA_W-1:0] b_rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Reads sample the array before this edge's write lands (read-first on both ports).
    always_ff @(posedge clk_i) begin
        a_rdata_q <= mem_q[a_addr_i];
        b_rdata_q <= mem_q[b_addr_i];
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/forward_table_server.sv
// Flow-table responder: 3-register lookup pipeline, management port, table clear, statistics.
// Define FWD_TABLE_PARITY_EN to store an even-parity bit per entry and check it on lookups.
module forward_table_server
    import forward_table_server_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] iv_ram_raddr,
    input  logic              i_ram_rd,
    output logic [DATA_W-1:0] ov_ram_rdata,
    output logic              o_ram_rdata_valid,
    input  logic [ADDR_W-1:0] iv_cfg_addr,
    input  logic [DATA_W-1:0] iv_cfg_wdata,
    input  logic              i_cfg_wr,
    input  logic              i_cfg_rd,
    output logic              o_cfg_ready,
    output logic [DATA_W-1:0] ov_cfg_rdata,
    output logic              o_cfg_rdata_valid,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  ov_hit_cnt,
    output logic [CNT_W-1:0]  ov_miss_cnt,
    output logic              o_parity_err
);

`ifdef FWD_TABLE_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              cfg_accept;
    logic              cfg_wr_q, cfg_rd_q, cfg_rd2_q;
    logic [ADDR_W-1:0] cfg_addr_q;
    logic [DATA_W-1:0] cfg_wdata_q;
    logic              lk_vld_q, lk2_vld_q, rdata_vld_q;
    logic [ADDR_W-1:0] lk_addr_q;
    logic [DATA_W-1:0] rdata_q, cfg_rdata_q, lk_data;
    logic              cfg_rdata_vld_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data_wr;
    logic [RAM_W-1:0]  b_wdata, a_rdata, b_rdata;
    logic              hit_inc, miss_inc;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cfg_accept = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                cfg_accept = 1'b1;
                // A write wins over a simultaneous read-back, so only a lone read waits.
                if (i_cfg_rd && !i_cfg_wr) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cfg_rd2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_wr_q    <= 1'b0;
            cfg_rd_q    <= 1'b0;
            cfg_rd2_q   <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
        end else begin
            cfg_wr_q  <= cfg_accept & i_cfg_wr;
            cfg_rd_q  <= cfg_accept & i_cfg_rd & ~i_cfg_wr;
            cfg_rd2_q <= cfg_rd_q;
            if (cfg_accept) begin
                cfg_addr_q  <= iv_cfg_addr;
                cfg_wdata_q <= iv_cfg_wdata;
            end
        end
    end

    // Port B is owned by the clear sweep during INIT, otherwise by the registered request.
    always_comb begin
        b_we      = (state_q == ST_INIT) | cfg_wr_q;
        b_addr    = (state_q == ST_INIT) ? init_cnt_q : cfg_addr_q;
        b_data_wr = (state_q == ST_INIT) ? '0 : cfg_wdata_q;
    end

`ifdef FWD_TABLE_PARITY_EN
    logic lk_perr, perr_q, b_par_unused;
    assign b_wdata      = {^b_data_wr, b_data_wr};
    assign lk_perr      = ^a_rdata;
    assign lk_data      = lk_perr ? '0 : a_rdata[DATA_W-1:0];
    assign b_par_unused = b_rdata[DATA_W];
    assign o_parity_err = perr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) perr_q <= 1'b0;
        else          perr_q <= lk2_vld_q & lk_perr;
    end
`else
    assign b_wdata      = b_data_wr;
    assign lk_data      = a_rdata;
    assign o_parity_err = 1'b0;
`endif

    table_ram_dp #(
        .ADDR_W (ADDR_W),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk_i     (i_clk),
        .a_addr_i  (lk_addr_q),
        .a_rdata_o (a_rdata),
        .b_we_i    (b_we),
        .b_addr_i  (b_addr),
        .b_wdata_i (b_wdata),
        .b_rdata_o (b_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lk_vld_q        <= 1'b0;
            lk_addr_q       <= '0;
            lk2_vld_q       <= 1'b0;
            rdata_vld_q     <= 1'b0;
            rdata_q         <= '0;
            cfg_rdata_vld_q <= 1'b0;
            cfg_rdata_q     <= '0;
        end else begin
            lk_vld_q        <= i_ram_rd;
            if (i_ram_rd) lk_addr_q <= iv_ram_raddr;
            lk2_vld_q       <= lk_vld_q;
            rdata_vld_q     <= lk2_vld_q;
            rdata_q         <= lk2_vld_q ? lk_data : '0;
            cfg_rdata_vld_q <= cfg_rd2_q;
            cfg_rdata_q     <= cfg_rd2_q ? b_rdata[DATA_W-1:0] : '0;
        end
    end

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic clr);
        logic [CNT_W-1:0] r;
        if (clr)                    r = {{(CNT_W-1){1'b0}}, inc};
        else if (inc && cnt != '1)  r = cnt + 1'b1;
        else                        r = cnt;
        return r;
    endfunction

    assign hit_inc  = rdata_vld_q && (rdata_q != '0);
    assign miss_inc = rdata_vld_q && (rdata_q == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= cnt_next(hit_cnt_q, hit_inc, i_cnt_clr);
            miss_cnt_q <= cnt_next(miss_cnt_q, miss_inc, i_cnt_clr);
        end
    end

    assign ov_ram_rdata      = rdata_q;
    assign o_ram_rdata_valid = rdata_vld_q;
    assign o_cfg_ready       = (state_q == ST_IDLE);
    assign ov_cfg_rdata      = cfg_rdata_q;
    assign o_cfg_rdata_valid = cfg_rdata_vld_q;
    assign ov_hit_cnt        = hit_cnt_q;
    assign ov_miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_forward_table_server.sv
// Directed bench for forward_table_server (ADDR_W=4); lookup results go through an expected queue.
// The parity block runs only when FWD_TABLE_PARITY_EN is defined.
module tb_forward_table_server;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 9;
    localparam int CNT_W  = 16;
    localparam int W      = DATA_W + 1;

    logic              i_clk;
    logic              i_rst_n;
    logic [ADDR_W-1:0] iv_ram_raddr;
    logic              i_ram_rd;
    logic [DATA_W-1:0] ov_ram_rdata;
    logic              o_ram_rdata_valid;
    logic [ADDR_W-1:0] iv_cfg_addr;
    logic [DATA_W-1:0] iv_cfg_wdata;
    logic              i_cfg_wr;
    logic              i_cfg_rd;
    logic              o_cfg_ready;
    logic [DATA_W-1:0] ov_cfg_rdata;
    logic              o_cfg_rdata_valid;
    logic              i_cnt_clr;
    logic [CNT_W-1:0]  ov_hit_cnt;
    logic [CNT_W-1:0]  ov_miss_cnt;
    logic              o_parity_err;

    forward_table_server #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .iv_ram_raddr      (iv_ram_raddr),
        .i_ram_rd          (i_ram_rd),
        .ov_ram_rdata      (ov_ram_rdata),
        .o_ram_rdata_valid (o_ram_rdata_valid),
        .iv_cfg_addr       (iv_cfg_addr),
        .iv_cfg_wdata      (iv_cfg_wdata),
        .i_cfg_wr          (i_cfg_wr),
        .i_cfg_rd          (i_cfg_rd),
        .o_cfg_ready       (o_cfg_ready),
        .ov_cfg_rdata      (ov_cfg_rdata),
        .o_cfg_rdata_valid (o_cfg_rdata_valid),
        .i_cnt_clr         (i_cnt_clr),
        .ov_hit_cnt        (ov_hit_cnt),
        .ov_miss_cnt       (ov_miss_cnt),
        .o_parity_err      (o_parity_err)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #4 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] model [2**ADDR_W];
    logic [W-1:0]      exp_q [$];
    logic [W-1:0]      sb_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every valid cycle pops one expected {parity_err, data}; idle cycles must be 0
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_ram_rdata_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_no_expect", 32'(exp_q.size()), 32'd1);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check_eq("lookup_data", {o_parity_err, ov_ram_rdata}, sb_exp);
                end
            end else begin
                check_eq("idle_out", {o_parity_err, ov_ram_rdata}, 0);
            end
        end
    end

    // driver tasks: inputs are applied, held across one rising edge, then released
    task automatic step(input logic rd, input logic [ADDR_W-1:0] raddr,
                        input logic wr, input logic crd, input logic [ADDR_W-1:0] caddr,
                        input logic [DATA_W-1:0] wdata, input logic clr);
        i_ram_rd     = rd;
        iv_ram_raddr = raddr;
        i_cfg_wr     = wr;
        i_cfg_rd     = crd;
        iv_cfg_addr  = caddr;
        iv_cfg_wdata = wdata;
        i_cnt_clr    = clr;
        if (rd) exp_q.push_back({1'b0, model[raddr]});
        @(posedge i_clk);
        #1;
        i_ram_rd  = 1'b0;
        i_cfg_wr  = 1'b0;
        i_cfg_rd  = 1'b0;
        i_cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic lookup(input logic [ADDR_W-1:0] a);
        step(1'b1, a, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        step(1'b0, '0, 1'b1, 1'b0, a, d, 1'b0);
        model[a] = d;
    endtask

    task automatic wait_init(input string tag);
        for (int i = 1; i <= 16; i++) begin
            @(negedge i_clk);
            if (i == 15) check_eq({tag, "_ready_lo"}, o_cfg_ready, 1'b0);
            if (i == 16) check_eq({tag, "_ready_hi"}, o_cfg_ready, 1'b1);
        end
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_ram_rd     = 1'b0;
        iv_ram_raddr = '0;
        i_cfg_wr     = 1'b0;
        i_cfg_rd     = 1'b0;
        iv_cfg_addr  = '0;
        iv_cfg_wdata = '0;
        i_cnt_clr    = 1'b0;
        for (int i = 0; i < 2**ADDR_W; i++) model[i] = '0;

        // reset values
        repeat (3) @(negedge i_clk);
        check_eq("rst_rdata", ov_ram_rdata, 0);
        check_eq("rst_rvalid", o_ram_rdata_valid, 0);
        check_eq("rst_ready", o_cfg_ready, 0);
        check_eq("rst_cfg_rdata", ov_cfg_rdata, 0);
        check_eq("rst_cfg_valid", o_cfg_rdata_valid, 0);
        check_eq("rst_hit", ov_hit_cnt, 0);
        check_eq("rst_miss", ov_miss_cnt, 0);
        check_eq("rst_perr", o_parity_err, 0);
        i_rst_n = 1'b1;
        wait_init("init");

        // every entry reads back as cleared
        for (int a = 0; a < 16; a++) lookup(4'(a));
        idle(4);
        check_eq("clr_miss", ov_miss_cnt, 16);
        check_eq("clr_hit", ov_hit_cnt, 0);

        // write then lookup with latency check
        cfg_write(4'd5, 9'h014);
        lookup(4'd5);
        @(negedge i_clk);
        check_eq("lat_e0", o_ram_rdata_valid, 0);
        @(negedge i_clk);
        check_eq("lat_e1", o_ram_rdata_valid, 0);
        @(negedge i_clk);
        check_eq("lat_e2_valid", o_ram_rdata_valid, 1);
        check_eq("lat_e2_data", ov_ram_rdata, 9'h014);
        idle(2);
        check_eq("w5_hit", ov_hit_cnt, 1);
        check_eq("w5_miss", ov_miss_cnt, 16);

        // read-first collision, then new data on the very next lookup
        step(1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 9'h101, 1'b0);
        model[3] = 9'h101;
        lookup(4'd3);
        idle(1);
        check_eq("rf_old_valid", o_ram_rdata_valid, 1);
        check_eq("rf_old_data", ov_ram_rdata, 9'h000);
        idle(1);
        check_eq("rf_new_valid", o_ram_rdata_valid, 1);
        check_eq("rf_new_data", ov_ram_rdata, 9'h101);
        idle(1);
        check_eq("rf_end_valid", o_ram_rdata_valid, 0);
        idle(1);
        check_eq("rf_hit", ov_hit_cnt, 2);
        check_eq("rf_miss", ov_miss_cnt, 17);

        // read-back with an ignored write during RD_WAIT
        step(1'b0, '0, 1'b0, 1'b1, 4'd5, '0, 1'b0);
        check_eq("rb_ready_c0", o_cfg_ready, 0);
        step(1'b0, '0, 1'b1, 1'b0, 4'd5, 9'h1FF, 1'b0);
        check_eq("rb_ready_c1", o_cfg_ready, 0);
        check_eq("rb_valid_c1", o_cfg_rdata_valid, 0);
        idle(1);
        check_eq("rb_ready_c2", o_cfg_ready, 1);
        check_eq("rb_valid_c2", o_cfg_rdata_valid, 1);
        check_eq("rb_data", ov_cfg_rdata, 9'h014);
        idle(1);
        check_eq("rb_valid_c3", o_cfg_rdata_valid, 0);
        lookup(4'd5);
        idle(4);
        check_eq("rb_hit", ov_hit_cnt, 3);

        // write and read-back together: write wins, read dropped
        step(1'b0, '0, 1'b1, 1'b1, 4'd9, 9'h0AA, 1'b0);
        model[9] = 9'h0AA;
        check_eq("wr_rd_ready", o_cfg_ready, 1);
        idle(2);
        check_eq("wr_rd_no_valid", o_cfg_rdata_valid, 0);
        lookup(4'd9);
        idle(4);
        check_eq("wr_rd_hit", ov_hit_cnt, 4);
        check_eq("wr_rd_miss", ov_miss_cnt, 17);

        // saturation
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        check_eq("clr_hit0", ov_hit_cnt, 0);
        check_eq("clr_miss0", ov_miss_cnt, 0);
        for (int i = 0; i < 65537; i++) lookup(4'd5);
        idle(4);
        check_eq("sat_hit", ov_hit_cnt, 16'hFFFF);
        check_eq("sat_miss", ov_miss_cnt, 0);
        lookup(4'd5);
        idle(2);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        check_eq("clr_inc_hit", ov_hit_cnt, 1);
        check_eq("clr_inc_miss", ov_miss_cnt, 0);

        // reset while a result is on the output
        cfg_write(4'd2, 9'h055);
        i_ram_rd     = 1'b1;
        iv_ram_raddr = 4'd2;
        @(posedge i_clk);
        #1;
        i_ram_rd = 1'b0;
        idle(2);
        check_eq("pre_rst_valid", o_ram_rdata_valid, 1);
        check_eq("pre_rst_data", ov_ram_rdata, 9'h055);
        i_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", o_ram_rdata_valid, 0);
        check_eq("mid_rst_data", ov_ram_rdata, 0);
        check_eq("mid_rst_ready", o_cfg_ready, 0);
        check_eq("mid_rst_hit", ov_hit_cnt, 0);
        for (int i = 0; i < 2**ADDR_W; i++) model[i] = '0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_init("reinit");
        lookup(4'd2);
        idle(4);
        check_eq("reinit_miss", ov_miss_cnt, 1);
        check_eq("reinit_hit", ov_hit_cnt, 0);

`ifdef FWD_TABLE_PARITY_EN
        cfg_write(4'd7, 9'h003);
        idle(1);
        dut.u_ram.mem_q[7][0] = ~dut.u_ram.mem_q[7][0];
        i_ram_rd     = 1'b1;
        iv_ram_raddr = 4'd7;
        exp_q.push_back({1'b1, 9'h000});
        @(posedge i_clk);
        #1;
        i_ram_rd = 1'b0;
        idle(4);
        check_eq("par_miss", ov_miss_cnt, 2);
        check_eq("par_hit", ov_hit_cnt, 0);
`endif

        check_eq("sb_drain", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
